// File: rtl/usb2_tx_pkg.sv
// rtl/usb2_tx_pkg.sv - shared types and constants for the USB2 HS transmit serializer
//
// Purpose: state encoding and line-level constants used by the serializer top
//          and its NRZI/bit-stuffing sub-module.
// Contents:
//   tx_state_e           - packet phase: IDLE, SYNC, DATA, EOP
//   EOP_PATTERN          - HS end-of-packet data bits, sent LSB-first
//   J_LEVEL              - idle line level
//   SYNC_LEN_DEFAULT     - default SYNC length in bits
//   STUFF_LIMIT_DEFAULT  - default run of data ones that forces a stuffed zero

package usb2_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] EOP_PATTERN         = 8'hFE;
  localparam logic       J_LEVEL             = 1'b1;
  localparam int         SYNC_LEN_DEFAULT    = 32;
  localparam int         STUFF_LIMIT_DEFAULT = 6;

endpackage

// File: rtl/usb2_tx_nrzi_stuffer.sv
// rtl/usb2_tx_nrzi_stuffer.sv - NRZI encoder with bit-stuff tracking and line register
//
// Purpose: turns one data bit per cycle into the registered NRZI line level and
//          decides when a stuffed zero must replace the next data bit.
// Ports:
//   clock     in  bit-rate clock
//   reset     in  synchronous active-high reset
//   bit_in    in  data bit offered this cycle
//   stuff_en  in  this bit takes part in stuffing (updates the ones count and
//                 may be replaced by a stuffed zero)
//   hold      in  no line bit this cycle: park the line at J, clear the count
//   stall     out ones count has reached the limit; with stuff_en high this
//                 cycle emits a stuffed zero and bit_in is not consumed
//   tx_data   out registered NRZI line bit (1 = J)

module usb2_tx_nrzi_stuffer
  import usb2_tx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_in,
  input  logic stuff_en,
  input  logic hold,
  output logic stall,
  output logic tx_data
);

  localparam int CW = $clog2(STUFF_LIMIT + 1);

  logic [CW-1:0] ones_cnt;

  assign stall = (ones_cnt == CW'(STUFF_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_data  <= J_LEVEL;
      ones_cnt <= '0;
    end else if (hold) begin
      tx_data  <= J_LEVEL;
      ones_cnt <= '0;
    end else if (stuff_en && stall) begin
      // Stuffed zero: NRZI toggle, run broken.
      tx_data  <= ~tx_data;
      ones_cnt <= '0;
    end else begin
      if (!bit_in) begin
        tx_data <= ~tx_data;
      end
      // EOP bits are sent with stuff_en low so they leave the count alone.
      if (stuff_en) begin
        ones_cnt <= bit_in ? (ones_cnt + CW'(1)) : '0;
      end
    end
  end

endmodule

// File: rtl/usb2_tx_serializer.sv
// rtl/usb2_tx_serializer.sv - USB2 high-speed transmit bit engine
//
// Purpose: takes packet bytes over a valid/ready handshake, emits SYNC, the
//          bytes LSB-first with bit stuffing, NRZI encoding and the HS EOP,
//          one line bit per clock.
// Ports:
//   clock      in   bit-rate clock
//   reset      in   synchronous active-high reset
//   tx_valid   in   link layer has a byte; low at a byte request ends the packet
//   data_in    in   packet byte, taken on the edge ending a tx_ready cycle
//   tx_ready   out  byte request/consume strobe, one cycle wide
//   tx_data    out  registered NRZI line bit (1 = J)
//   tx_enable  out  registered line-driver enable

module usb2_tx_serializer
  import usb2_tx_pkg::*;
#(
  parameter int SYNC_LEN    = SYNC_LEN_DEFAULT,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] data_in,
  output logic       tx_ready,
  output logic       tx_data,
  output logic       tx_enable
);

  localparam int             SCW       = $clog2(SYNC_LEN);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_LEN - 1);

  tx_state_e      state, state_d;
  logic [SCW-1:0] sync_cnt, sync_cnt_d;
  logic [2:0]     bit_cnt, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           line_bit;
  logic           stuff_en;
  logic           hold;
  logic           stall;
  logic           stuffing;
  logic           ready_raw;
  logic           tx_enable_q;

  // The ones count is cleared in IDLE, so a stall can only be pending once a
  // packet is under way. In EOP it is the stuff owed by the final data bit.
  assign stuffing = stall && (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      sync_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      tx_enable_q <= 1'b0;
    end else begin
      state       <= state_d;
      sync_cnt    <= sync_cnt_d;
      bit_cnt     <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_enable_q <= ~hold;
    end
  end

  always_comb begin
    state_d    = state;
    sync_cnt_d = sync_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    line_bit   = 1'b0;
    stuff_en   = 1'b0;
    hold       = 1'b0;
    ready_raw  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          // SYNC bit 0 goes out on the same edge that leaves IDLE.
          stuff_en   = 1'b1;
          state_d    = ST_SYNC;
          sync_cnt_d = SCW'(1);
        end else begin
          hold = 1'b1;
        end
      end
      ST_SYNC: begin
        stuff_en = 1'b1;
        line_bit = (sync_cnt == SYNC_LAST);
        if (!stuffing) begin
          if (sync_cnt == SYNC_LAST) begin
            ready_raw = 1'b1;
            bit_cnt_d = '0;
            if (tx_valid) begin
              shift_d = data_in;
              state_d = ST_DATA;
            end else begin
              state_d = ST_EOP;
            end
          end else begin
            sync_cnt_d = sync_cnt + SCW'(1);
          end
        end
      end
      ST_DATA: begin
        stuff_en = 1'b1;
        line_bit = shift_q[0];
        if (!stuffing) begin
          if (bit_cnt == 3'd7) begin
            ready_raw = 1'b1;
            bit_cnt_d = '0;
            if (tx_valid) begin
              shift_d = data_in;
            end else begin
              shift_d = '0;
              state_d = ST_EOP;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      ST_EOP: begin
        stuff_en = stall;
        line_bit = EOP_PATTERN[bit_cnt];
        if (!stuffing) begin
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  usb2_tx_nrzi_stuffer #(
    .STUFF_LIMIT(STUFF_LIMIT)
  ) u_nrzi_stuffer (
    .clock   (clock),
    .reset   (reset),
    .bit_in  (line_bit),
    .stuff_en(stuff_en),
    .hold    (hold),
    .stall   (stall),
    .tx_data (tx_data)
  );

  // Masked during reset so a request cannot be seen on the edge that aborts.
  assign tx_ready  = ready_raw & ~reset;
  assign tx_enable = tx_enable_q;

endmodule
